// File: rtl/rv_serdes_pkg.sv
// Shared constants for the valid/ready serializer and deserializer pair.
package rv_serdes_pkg;

  // Chunk order selectors; both ends of a link must use the same value.
  localparam int unsigned SER_LSB_FIRST = 1;
  localparam int unsigned SER_MSB_FIRST = 0;

endpackage

// File: rtl/rv_serializer.sv
// Parallel-in / serial-out shifter: one N-chunk word in on valid/ready, N DATAW-bit chunks out.
module rv_serializer
  import rv_serdes_pkg::*;
#(
  parameter int unsigned DATAW     = 8,
  parameter int unsigned N         = 4,
  parameter int unsigned LSB_FIRST = SER_LSB_FIRST,
  parameter int unsigned CNTW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [N*DATAW-1:0] data_in,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [DATAW-1:0]   data_out,
  output logic               last_out
);

  localparam logic [CNTW-1:0] LastIdx = CNTW'(N - 1);

  logic               valid_q;
  logic               last_q;
  logic [CNTW-1:0]    count_q;
  logic [N*DATAW-1:0] shift_q;

  // Accept a new word when idle, or when the final chunk leaves this cycle (no bubble).
  assign ready_in  = !valid_q || (last_q && ready_out);
  assign valid_out = valid_q;
  assign last_out  = last_q;

  // The output chunk always sits at the output end of the shift register.
  assign data_out = (LSB_FIRST != 0) ? shift_q[DATAW-1:0] : shift_q[N*DATAW-1 -: DATAW];

  // Counter, shift register and valid flag; a load takes priority over draining the last chunk.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      count_q <= '0;
      shift_q <= '0;
    end else if (valid_in && ready_in) begin
      valid_q <= 1'b1;
      last_q  <= (N == 1);
      count_q <= '0;
      shift_q <= data_in;
    end else if (valid_q && ready_out) begin
      if (last_q) begin
        // Keep shift_q so data_out holds its last value while idle.
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        count_q <= '0;
      end else begin
        count_q <= count_q + CNTW'(1);
        last_q  <= ((count_q + CNTW'(1)) == LastIdx);
        shift_q <= (LSB_FIRST != 0) ? (shift_q >> DATAW) : (shift_q << DATAW);
      end
    end
  end

endmodule

// File: tb/tb_rv_serializer.sv
// Directed, table-driven bench for rv_serializer (LSB-first, MSB-first and N=1 builds).
module tb_rv_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        vin;
  logic [31:0] din;
  logic        ro;

  logic        ri_l, vo_l, lo_l;
  logic [7:0]  do_l;
  logic        ri_m, vo_m, lo_m;
  logic [7:0]  do_m;

  logic        v1, r1;
  logic [7:0]  d1;
  logic        ri_1, vo_1, lo_1;
  logic [7:0]  do_1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_serializer #(.DATAW(8), .N(4), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .reset(reset), .valid_in(vin), .ready_in(ri_l), .data_in(din),
    .valid_out(vo_l), .ready_out(ro), .data_out(do_l), .last_out(lo_l)
  );

  rv_serializer #(.DATAW(8), .N(4), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .valid_in(vin), .ready_in(ri_m), .data_in(din),
    .valid_out(vo_m), .ready_out(ro), .data_out(do_m), .last_out(lo_m)
  );

  rv_serializer #(.DATAW(8), .N(1), .LSB_FIRST(1)) u_n1 (
    .clk(clk), .reset(reset), .valid_in(v1), .ready_in(ri_1), .data_in(d1),
    .valid_out(vo_1), .ready_out(r1), .data_out(do_1), .last_out(lo_1)
  );

  typedef struct {
    logic        rst;
    logic        vin;
    logic [31:0] din;
    logic        ro;
    logic        evo;
    logic        elo;
    logic        eri;
    logic [7:0]  elsb;
    logic [7:0]  emsb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic v, input logic [31:0] d, input logic r,
                     input logic evo, input logic elo, input logic eri,
                     input logic [7:0] elsb, input logic [7:0] emsb);
    vec_t x;
    x.rst = rst; x.vin = v; x.din = d; x.ro = r;
    x.evo = evo; x.elo = elo; x.eri = eri; x.elsb = elsb; x.emsb = emsb;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // One N=1 cycle: drive, check pre-edge outputs, advance to the next falling edge.
  task automatic n1_step(input int idx, input logic v, input logic [7:0] d, input logic r,
                         input logic evo, input logic elo, input logic eri,
                         input logic [7:0] edo);
    v1 = v; d1 = d; r1 = r;
    #1;
    check("n1_valid_out", idx, 32'(vo_1), 32'(evo));
    check("n1_last_out",  idx, 32'(lo_1), 32'(elo));
    check("n1_ready_in",  idx, 32'(ri_1), 32'(eri));
    check("n1_data_out",  idx, 32'(do_1), 32'(edo));
    @(negedge clk);
  endtask

  initial begin
    // Reset held two cycles with valid_in high; the word must not be taken.
    reset = 1'b1; vin = 1'b1; din = 32'hDDCC_BBAA; ro = 1'b1;
    v1 = 1'b0; d1 = 8'h00; r1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    //  rst vin din           ro  evo elo eri  lsb    msb
    add(0, 1, 32'hDDCC_BBAA, 1,  0,  0,  1,  8'h00, 8'h00); // post-reset, load
    add(0, 0, 32'h0,         1,  1,  0,  0,  8'hAA, 8'hDD);
    add(0, 0, 32'h0,         1,  1,  0,  0,  8'hBB, 8'hCC);
    add(0, 0, 32'h0,         1,  1,  0,  0,  8'hCC, 8'hBB);
    add(0, 0, 32'h0,         1,  1,  1,  1,  8'hDD, 8'hAA);
    add(0, 1, 32'h0403_0201, 1,  0,  0,  1,  8'hDD, 8'hAA); // idle holds last chunk
    add(0, 1, 32'h0807_0605, 1,  1,  0,  0,  8'h01, 8'h04);
    add(0, 1, 32'h0807_0605, 1,  1,  0,  0,  8'h02, 8'h03);
    add(0, 1, 32'h0807_0605, 1,  1,  0,  0,  8'h03, 8'h02);
    add(0, 1, 32'h0807_0605, 1,  1,  1,  1,  8'h04, 8'h01); // back-to-back load
    add(0, 0, 32'h0,         1,  1,  0,  0,  8'h05, 8'h08);
    add(0, 0, 32'h0,         1,  1,  0,  0,  8'h06, 8'h07);
    add(0, 0, 32'h0,         1,  1,  0,  0,  8'h07, 8'h06);
    add(0, 0, 32'h0,         1,  1,  1,  1,  8'h08, 8'h05);
    add(0, 1, 32'hDDCC_BBAA, 1,  0,  0,  1,  8'h08, 8'h05);
    add(0, 0, 32'h0,         1,  1,  0,  0,  8'hAA, 8'hDD);
    add(0, 1, 32'h1234_5678, 0,  1,  0,  0,  8'hBB, 8'hCC); // stall, data_in ignored
    add(0, 1, 32'h1234_5678, 0,  1,  0,  0,  8'hBB, 8'hCC);
    add(0, 1, 32'h1234_5678, 0,  1,  0,  0,  8'hBB, 8'hCC);
    add(0, 0, 32'h0,         1,  1,  0,  0,  8'hBB, 8'hCC);
    add(0, 0, 32'h0,         1,  1,  0,  0,  8'hCC, 8'hBB);
    add(0, 0, 32'h0,         1,  1,  1,  1,  8'hDD, 8'hAA);
    add(0, 1, 32'hDDCC_BBAA, 1,  0,  0,  1,  8'hDD, 8'hAA);
    add(0, 0, 32'h0,         1,  1,  0,  0,  8'hAA, 8'hDD);
    add(1, 0, 32'h0,         1,  1,  0,  0,  8'hBB, 8'hCC); // reset mid-word
    add(0, 0, 32'h0,         1,  0,  0,  1,  8'h00, 8'h00);
    add(0, 1, 32'h4433_2211, 1,  0,  0,  1,  8'h00, 8'h00);
    add(0, 0, 32'h0,         1,  1,  0,  0,  8'h11, 8'h44);
    add(0, 0, 32'h0,         1,  1,  0,  0,  8'h22, 8'h33);
    add(0, 0, 32'h0,         1,  1,  0,  0,  8'h33, 8'h22);
    add(0, 0, 32'h0,         1,  1,  1,  1,  8'h44, 8'h11);
    add(0, 0, 32'h0,         1,  0,  0,  1,  8'h44, 8'h11);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; vin = vecs[i].vin; din = vecs[i].din; ro = vecs[i].ro;
      #1;
      check("lsb_valid_out", i, 32'(vo_l), 32'(vecs[i].evo));
      check("lsb_last_out",  i, 32'(lo_l), 32'(vecs[i].elo));
      check("lsb_ready_in",  i, 32'(ri_l), 32'(vecs[i].eri));
      check("lsb_data_out",  i, 32'(do_l), 32'(vecs[i].elsb));
      check("msb_valid_out", i, 32'(vo_m), 32'(vecs[i].evo));
      check("msb_last_out",  i, 32'(lo_m), 32'(vecs[i].elo));
      check("msb_data_out",  i, 32'(do_m), 32'(vecs[i].emsb));
      @(negedge clk);
    end
    reset = 1'b0; vin = 1'b0;

    // N=1: full-rate pipeline register, stall holds, data_in ignored while stalled.
    n1_step(100, 1, 8'h5A, 1, 0, 0, 1, 8'h00);
    n1_step(101, 1, 8'hA5, 1, 1, 1, 1, 8'h5A);
    n1_step(102, 1, 8'h3C, 0, 1, 1, 0, 8'hA5);
    n1_step(103, 1, 8'h77, 0, 1, 1, 0, 8'hA5);
    n1_step(104, 0, 8'h00, 1, 1, 1, 1, 8'hA5);
    n1_step(105, 0, 8'h00, 1, 0, 0, 1, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
